// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side signal bundle for hazard_stall_controller.
// StallCnt/FlushCnt exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_stall_controller_if #(
    parameter int PERF_W = 32
);
    logic [4:0] rs_IF_ID;
    logic [4:0] rt_IF_ID;
    logic       UsesRt_IF_ID;
    logic       MdUse_IF_ID;
    logic [4:0] rt_ID_EX;
    logic       MemRead_ID_EX;
    logic       MdStart_ID_EX;
    logic       Redirect_EX;
    logic       PCWrite;
    logic       IF_ID_Write;
    logic       IF_ID_Flush;
    logic       ID_EX_Bubble;
    logic       MD_Busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] StallCnt;
    logic [PERF_W-1:0] FlushCnt;

    modport master (
        output rs_IF_ID, rt_IF_ID, UsesRt_IF_ID, MdUse_IF_ID,
               rt_ID_EX, MemRead_ID_EX, MdStart_ID_EX, Redirect_EX,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MD_Busy,
               StallCnt, FlushCnt
    );

    modport slave (
        input  rs_IF_ID, rt_IF_ID, UsesRt_IF_ID, MdUse_IF_ID,
               rt_ID_EX, MemRead_ID_EX, MdStart_ID_EX, Redirect_EX,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MD_Busy,
               StallCnt, FlushCnt
    );
`else
    modport master (
        output rs_IF_ID, rt_IF_ID, UsesRt_IF_ID, MdUse_IF_ID,
               rt_ID_EX, MemRead_ID_EX, MdStart_ID_EX, Redirect_EX,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MD_Busy
    );

    modport slave (
        input  rs_IF_ID, rt_IF_ID, UsesRt_IF_ID, MdUse_IF_ID,
               rt_ID_EX, MemRead_ID_EX, MdStart_ID_EX, Redirect_EX,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MD_Busy
    );
`endif
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use / mul-div stall and redirect-flush controller for the 5-stage MIPS pipeline.
// Optional stall/flush performance counters are compiled in with HAZARD_PERF_CNT_EN.
module hazard_stall_controller #(
    parameter int MD_LATENCY = 32,
    parameter int MD_CNT_W   = 6,
    parameter int PERF_W     = 32
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    hazard_stall_controller_if.slave    hz
);

    localparam logic [0:0] S_RUN     = 1'b0;
    localparam logic [0:0] S_MD_BUSY = 1'b1;

    logic [0:0]          state;
    logic [MD_CNT_W-1:0] md_cnt;
    logic                md_busy;
    logic                load_use;
    logic                md_hazard;
    logic                stall;
    logic                pc_write;
    logic                if_id_write;
    logic                if_id_flush;
    logic                id_ex_bubble;

    // A start seen while already busy is ignored; only S_RUN accepts it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= S_RUN;
            md_cnt <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (hz.MdStart_ID_EX) begin
                        state  <= S_MD_BUSY;
                        md_cnt <= MD_CNT_W'(MD_LATENCY);
                    end
                end
                S_MD_BUSY: begin
                    if (md_cnt == MD_CNT_W'(1)) begin
                        state  <= S_RUN;
                        md_cnt <= '0;
                    end else begin
                        md_cnt <= md_cnt - MD_CNT_W'(1);
                    end
                end
                default: begin
                    state  <= S_RUN;
                    md_cnt <= '0;
                end
            endcase
        end
    end

    assign md_busy   = (state == S_MD_BUSY);
    assign load_use  = hz.MemRead_ID_EX && (hz.rt_ID_EX != 5'd0) &&
                       ((hz.rt_ID_EX == hz.rs_IF_ID) ||
                        (hz.UsesRt_IF_ID && (hz.rt_ID_EX == hz.rt_IF_ID)));
    assign md_hazard = hz.MdUse_IF_ID && (md_busy || hz.MdStart_ID_EX);
    assign stall     = load_use || md_hazard;

    // Redirect outranks any stall; reset overrides everything asynchronously.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (!Reset_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (hz.Redirect_EX) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    assign hz.PCWrite      = pc_write;
    assign hz.IF_ID_Write  = if_id_write;
    assign hz.IF_ID_Flush  = if_id_flush;
    assign hz.ID_EX_Bubble = id_ex_bubble;
    assign hz.MD_Busy      = md_busy;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hz.Redirect_EX) begin
                flush_cnt <= flush_cnt + PERF_W'(1);
            end else if (stall) begin
                stall_cnt <= stall_cnt + PERF_W'(1);
            end
        end
    end

    assign hz.StallCnt = stall_cnt;
    assign hz.FlushCnt = flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: one instance with MD_LATENCY=4, one with MD_LATENCY=1.
module tb_hazard_stall_controller;

    logic Clk;
    logic Reset_n;
    int   errors;
    int   checks;

    localparam logic [3:0] C_RESET    = 4'b0011;
    localparam logic [3:0] C_NORMAL   = 4'b1100;
    localparam logic [3:0] C_STALL    = 4'b0001;
    localparam logic [3:0] C_REDIRECT = 4'b1111;

    hazard_stall_controller_if #(.PERF_W(32)) hz4 ();
    hazard_stall_controller_if #(.PERF_W(32)) hz1 ();

    hazard_stall_controller #(.MD_LATENCY(4), .MD_CNT_W(6), .PERF_W(32)) dut4 (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .hz      (hz4.slave)
    );

    hazard_stall_controller #(.MD_LATENCY(1), .MD_CNT_W(6), .PERF_W(32)) dut1 (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .hz      (hz1.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic applyStimulus(input logic mem_read, input logic [4:0] rt_ex,
                                 input logic [4:0] rs_id, input logic [4:0] rt_id,
                                 input logic uses_rt, input logic md_use,
                                 input logic md_start, input logic redirect);
        hz4.MemRead_ID_EX = mem_read;
        hz4.rt_ID_EX      = rt_ex;
        hz4.rs_IF_ID      = rs_id;
        hz4.rt_IF_ID      = rt_id;
        hz4.UsesRt_IF_ID  = uses_rt;
        hz4.MdUse_IF_ID   = md_use;
        hz4.MdStart_ID_EX = md_start;
        hz4.Redirect_EX   = redirect;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] exp_ctrl, input logic exp_busy);
        logic [3:0] obs_ctrl;
        obs_ctrl = {hz4.PCWrite, hz4.IF_ID_Write, hz4.IF_ID_Flush, hz4.ID_EX_Bubble};
        checks++;
        assert (obs_ctrl === exp_ctrl) else begin
            errors++;
            $error("[TB] FAIL %s ctrl observed=%b expected=%b", tag, obs_ctrl, exp_ctrl);
        end
        checks++;
        assert (hz4.MD_Busy === exp_busy) else begin
            errors++;
            $error("[TB] FAIL %s busy observed=%b expected=%b", tag, hz4.MD_Busy, exp_busy);
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        checks++;
        assert (obs === exp_val) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp_val);
        end
    endtask

    task automatic nextCycle();
        @(posedge Clk);
        #1;
    endtask

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_snap;
    logic [31:0] flush_snap;
`endif

    initial begin
        errors = 0;
        checks = 0;
        Reset_n = 1'b0;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        hz1.MemRead_ID_EX = 1'b0;
        hz1.rt_ID_EX      = 5'd0;
        hz1.rs_IF_ID      = 5'd0;
        hz1.rt_IF_ID      = 5'd0;
        hz1.UsesRt_IF_ID  = 1'b0;
        hz1.MdUse_IF_ID   = 1'b0;
        hz1.MdStart_ID_EX = 1'b0;
        hz1.Redirect_EX   = 1'b0;

        #3;
        checkOutput("reset_state", C_RESET, 1'b0);
        @(negedge Clk);
        Reset_n = 1'b1;
        nextCycle();

        @(negedge Clk);
        checkOutput("idle_normal", C_NORMAL, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        checkValue("stallcnt_reset", hz4.StallCnt, 32'd0);
        checkValue("flushcnt_reset", hz4.FlushCnt, 32'd0);
`endif

        // T1: load-use on rs lasts one cycle, then the load has moved on
        nextCycle();
        applyStimulus(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        checkOutput("t1_loaduse_rs", C_STALL, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        checkOutput("t1_after_stall", C_NORMAL, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        checkValue("t1_stallcnt", hz4.StallCnt, 32'd1);
`endif

        // rt match only counts when the ID instruction reads rt
        nextCycle();
        applyStimulus(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        checkOutput("loaduse_rt_used", C_STALL, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        checkOutput("loaduse_rt_unused", C_NORMAL, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        checkOutput("no_memread", C_NORMAL, 1'b0);

        // T2: register 0 never stalls
        nextCycle();
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        checkOutput("t2_reg0", C_NORMAL, 1'b0);

        // T4: redirect beats load-use
        nextCycle();
        applyStimulus(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge Clk);
        checkOutput("t4_redirect", C_REDIRECT, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        stall_snap = hz4.StallCnt;
        flush_snap = hz4.FlushCnt;
`endif
        nextCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        checkOutput("t4_after", C_NORMAL, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        checkValue("t4_stallcnt_same", hz4.StallCnt, stall_snap);
        checkValue("t4_flushcnt_inc", hz4.FlushCnt, flush_snap + 32'd1);
`endif

        // T3: start plus dependent mfhi: 5 stall cycles, proceed on the 6th
        nextCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge Clk);
        checkOutput("t3_start_cycle", C_STALL, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge Clk);
            checkOutput($sformatf("t3_busy_%0d", i), C_STALL, 1'b1);
            nextCycle();
        end
        @(negedge Clk);
        checkOutput("t3_release", C_NORMAL, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        checkValue("t3_stallcnt", hz4.StallCnt, 32'd7);
`endif

        // Redirect during busy does not disturb the countdown
        nextCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge Clk);
        checkOutput("busy_redirect", C_REDIRECT, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        @(negedge Clk);
        checkOutput("busy_redirect_last", C_NORMAL, 1'b1);
        nextCycle();
        @(negedge Clk);
        checkOutput("busy_redirect_done", C_NORMAL, 1'b0);

        // T6: second start during busy is ignored
        nextCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        nextCycle();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, (i == 2), 1'b0);
            @(negedge Clk);
            checkOutput($sformatf("t6_restart_busy_%0d", i), C_NORMAL, 1'b1);
            nextCycle();
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        checkOutput("t6_restart_ignored", C_NORMAL, 1'b0);

        // T6: MD_LATENCY=1 busy for exactly one cycle
        nextCycle();
        hz1.MdStart_ID_EX = 1'b1;
        @(negedge Clk);
        checkValue("t6_lat1_before", {31'd0, hz1.MD_Busy}, 32'd0);
        nextCycle();
        hz1.MdStart_ID_EX = 1'b0;
        @(negedge Clk);
        checkValue("t6_lat1_busy", {31'd0, hz1.MD_Busy}, 32'd1);
        nextCycle();
        @(negedge Clk);
        checkValue("t6_lat1_done", {31'd0, hz1.MD_Busy}, 32'd0);

        // T5: reset in busy cycle 2 clears MD_Busy without waiting for a clock
        nextCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        checkOutput("t5_busy1", C_NORMAL, 1'b1);
        nextCycle();
        #1;
        Reset_n = 1'b0;
        #1;
        checkOutput("t5_async_reset", C_RESET, 1'b0);
        @(negedge Clk);
        Reset_n = 1'b1;
        nextCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge Clk);
        checkOutput("t5_after_reset", C_NORMAL, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        checkValue("t5_stallcnt_cleared", hz4.StallCnt, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
